// File: rtl/ready_skid_buffer_pkg.sv
// Shared types and constants for the ready-path skid buffer.
package ready_skid_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        BUSY,
        FULL
    } skid_state_t;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

endpackage

// File: rtl/ready_skid_buffer_sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over increment.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ready_skid_buffer.sv
// Two-entry skid buffer: registers in_ready so out_ready never reaches it combinationally.
module ready_skid_buffer
    import ready_skid_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0]                 occupancy,
    output logic [STALL_CNT_WIDTH-1:0] stall_cnt,
    input  logic                       stall_clr
);

    skid_state_t           state;
    skid_state_t           next_state;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  in_fire;
    logic                  out_fire;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign out_data = main_q;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            EMPTY:   if (in_fire) next_state = BUSY;
            BUSY: begin
                if (in_fire && !out_fire)      next_state = FULL;
                else if (!in_fire && out_fire) next_state = EMPTY;
            end
            FULL:    if (out_fire) next_state = BUSY;
            default: next_state = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        occupancy = OCC_EMPTY;
        case (state)
            BUSY: begin
                out_valid = 1'b1;
                occupancy = OCC_ONE;
            end
            FULL: begin
                out_valid = 1'b1;
                occupancy = OCC_TWO;
            end
            default: ;
        endcase
    end

    // NOTE: the data registers are reset only so out_data is defined after reset; they are never cleared on drain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= EMPTY;
            in_ready <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else begin
            state    <= next_state;
            in_ready <= (next_state != FULL);
            case (state)
                EMPTY: if (in_fire) main_q <= in_data;
                BUSY: begin
                    if (in_fire && out_fire) main_q <= in_data;
                    else if (in_fire)        skid_q <= in_data;
                end
                FULL:  if (out_fire) main_q <= skid_q;
                default: ;
            endcase
        end
    end

    sat_counter #(
        .WIDTH(STALL_CNT_WIDTH)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (out_valid && !out_ready),
        .clr   (stall_clr),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_ready_skid_buffer.sv
// Self-checking bench: a queue-based model of the two-entry buffer drives every expectation.
module tb_ready_skid_buffer;

    localparam int DW      = 8;
    localparam int SW      = 4;
    localparam int SAT_MAX = (1 << SW) - 1;

    logic          clk;
    logic          reset;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    occupancy;
    logic [SW-1:0] stall_cnt;
    logic          stall_clr;

    ready_skid_buffer #(
        .DATA_WIDTH      (DW),
        .STALL_CNT_WIDTH (SW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt),
        .stall_clr (stall_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a FIFO of at most two beats; upstream may push when it held fewer than two.
    logic [DW-1:0] model_q[$];
    logic          m_ready;
    int            m_stall;
    logic          have_edge;
    logic          ready_after_edge;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        model_q.delete();
        m_ready   = 1'b0;
        m_stall   = 0;
        have_edge = 1'b0;
    endtask

    // One clock cycle: drive after the falling edge, check, then advance model across the rising edge.
    task automatic cycle(input logic iv, input logic [DW-1:0] d, input logic ordy,
                         input logic clr, output logic acc);
        logic mv, ifire, ofire;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        stall_clr = clr;
        #1;
        mv = (model_q.size() > 0);
        check("in_ready", in_ready, m_ready);
        check("out_valid", out_valid, mv);
        check("occupancy", occupancy, model_q.size());
        if (mv) check("out_data", out_data, model_q[0]);
        check("stall_cnt", stall_cnt, m_stall);
        if (have_edge) check("in_ready_stable", in_ready, ready_after_edge);
        ifire = iv && m_ready;
        ofire = mv && ordy;
        @(posedge clk);
        if (ofire) void'(model_q.pop_front());
        if (ifire) model_q.push_back(d);
        m_ready = (model_q.size() < 2);
        if (clr) m_stall = 0;
        else if (mv && !ordy && m_stall < SAT_MAX) m_stall++;
        acc = ifire;
        #1;
        ready_after_edge = in_ready;
        have_edge        = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        stall_clr = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [DW-1:0] v;
        logic          acc;
        int            guard;
        int            beats;

        model_reset();
        do_reset();

        // Reset then stream 1..8 with both sides ready.
        check("rst_out_valid", out_valid, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_in_ready", in_ready, 0);
        v = 8'd1;
        guard = 0;
        while (v <= 8'd8 && guard < 50) begin
            cycle(1'b1, v, 1'b1, 1'b0, acc);
            if (acc) v++;
            guard++;
        end
        check("stream_accepted", v, 9);
        repeat (2) cycle(1'b0, 8'h00, 1'b1, 1'b0, acc);
        check("stream_stall_end", stall_cnt, 0);

        // Back-pressure absorb.
        v = 8'h10;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, v, (i < 3), 1'b0, acc);
            if (acc) v++;
        end
        check("bp_full_occ", occupancy, 2);
        check("bp_full_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, acc);
        check("bp_drained", occupancy, 0);

        // Random valid/ready, 1000 beats.
        beats = 0;
        guard = 0;
        while (beats < 1000 && guard < 10000) begin
            cycle($urandom_range(0, 1), 8'($urandom_range(0, 255)), $urandom_range(0, 1),
                  ($urandom_range(0, 15) == 0), acc);
            if (acc) beats++;
            guard++;
        end
        check("random_beats", beats, 1000);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, acc);
        check("random_drained", occupancy, 0);

        // Stall saturation: fill one beat and hold out_ready low.
        cycle(1'b1, 8'hA5, 1'b1, 1'b1, acc);
        for (int i = 0; i < 20; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, acc);
        check("stall_saturated", stall_cnt, SAT_MAX);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
        check("stall_clr_wins", stall_cnt, 0);

        // Reset mid-operation while FULL.
        cycle(1'b1, 8'h5A, 1'b0, 1'b0, acc);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, acc);
        check("pre_rst_occ", occupancy, 2);
        #2 reset = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_occ", occupancy, 0);
        check("async_rst_ready", in_ready, 0);
        check("async_rst_stall", stall_cnt, 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, acc);
        check("post_rst_empty", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
